// File: rtl/axi_traffic_gen.sv
// AXI4 burst traffic generator: writes a seeded incrementing pattern, reads it back
// and checks it, one outstanding transaction at a time, with sticky error status.

module axi_traffic_gen_lane #(
  parameter int LANE      = 0,
  parameter int NUM_LANES = 4
) (
  input  logic [31:0] seed,
  input  logic [31:0] gbeat,
  input  logic [31:0] rdata,
  output logic [31:0] pat,
  output logic        mis
);
  assign pat = seed + gbeat * 32'(NUM_LANES) + 32'(LANE);
  assign mis = (rdata != pat);
endmodule

module axi_traffic_gen #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128,
  parameter int ID_WIDTH   = 4,
  parameter int MAX_BEATS  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [15:0]             num_txn,
  input  logic [7:0]              beats,
  input  logic [31:0]             seed,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [15:0]             err_count,
  output logic [ADDR_WIDTH-1:0]   first_err_addr,
  output logic [ID_WIDTH-1:0]     awid,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [ID_WIDTH-1:0]     bid,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready,
  output logic [ID_WIDTH-1:0]     arid,
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [ID_WIDTH-1:0]     rid,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready
);
  localparam int NUM_LANES = DATA_WIDTH / 32;
  localparam int BYTES     = DATA_WIDTH / 8;
  localparam int SIZE      = $clog2(BYTES);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_WR_RESP, S_RD, S_RD_DATA, S_DONE} state_t;

  typedef struct packed {
    logic                  rd_phase;
    logic [ADDR_WIDTH-1:0] base;
    logic [15:0]           num;
    logic [7:0]            len;
    logic [31:0]           seed;
  } cfg_t;

  state_t                state, state_nx;
  cfg_t                  cfg;
  logic [15:0]           txn;
  logic [7:0]            beat;
  logic [31:0]           gbeat;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic                  aw_done, w_done, done_q, error_q;
  logic [15:0]           err_cnt;
  logic [ADDR_WIDTH-1:0] first_addr;

  logic [NUM_LANES-1:0][31:0] pat;
  logic [NUM_LANES-1:0]       lane_mis;
  logic [7:0]                 start_len;
  logic [ADDR_WIDTH-1:0]      stride;
  logic [ID_WIDTH-1:0]        exp_id;
  logic                       start_acc, last_beat, more;
  logic                       aw_hs, w_hs, w_last_hs, b_hs, r_hs;
  logic [2:0]                 err_inc;
  logic [16:0]                err_sum;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    axi_traffic_gen_lane #(.LANE(i), .NUM_LANES(NUM_LANES)) u_lane (
      .seed  (cfg.seed),
      .gbeat (gbeat),
      .rdata (rdata[i*32 +: 32]),
      .pat   (pat[i]),
      .mis   (lane_mis[i])
    );
  end

  // Out-of-range burst lengths fall back to the largest supported burst.
  always_comb begin
    start_len = beats - 8'd1;
    if (beats == 8'd0 || 32'(beats) > MAX_BEATS) start_len = 8'(MAX_BEATS - 1);
  end

  assign stride    = ADDR_WIDTH'(9'(cfg.len) + 9'd1) << SIZE;
  assign exp_id    = txn[ID_WIDTH-1:0];
  assign start_acc = start && (state == S_IDLE || state == S_DONE);
  assign last_beat = (beat == cfg.len);
  assign more      = (17'(txn) + 17'd1) < 17'(cfg.num);

  assign awvalid = (state == S_WR) && !aw_done;
  assign wvalid  = (state == S_WR) && !w_done;
  assign bready  = (state == S_WR_RESP);
  assign arvalid = (state == S_RD);
  assign rready  = (state == S_RD_DATA);

  assign aw_hs     = awvalid && awready;
  assign w_hs      = wvalid && wready;
  assign w_last_hs = w_hs && last_beat;
  assign b_hs      = bready && bvalid;
  assign r_hs      = rready && rvalid;

  // Payloads are zeroed while their valid is low so idle/reset buses read as 0.
  assign awid    = awvalid ? exp_id : '0;
  assign awaddr  = awvalid ? cur_addr : '0;
  assign awlen   = awvalid ? cfg.len : '0;
  assign awsize  = awvalid ? 3'(SIZE) : '0;
  assign awburst = awvalid ? 2'b01 : '0;
  assign arid    = arvalid ? exp_id : '0;
  assign araddr  = arvalid ? cur_addr : '0;
  assign arlen   = arvalid ? cfg.len : '0;
  assign arsize  = arvalid ? 3'(SIZE) : '0;
  assign arburst = arvalid ? 2'b01 : '0;
  assign wdata   = wvalid ? pat : '0;
  assign wstrb   = wvalid ? '1 : '0;
  assign wlast   = wvalid && last_beat;

  assign busy           = (state != S_IDLE) && (state != S_DONE);
  assign done           = done_q || (state == S_DONE);
  assign error          = error_q;
  assign err_count      = err_cnt;
  assign first_err_addr = first_addr;

  always_comb begin
    err_inc = '0;
    if (b_hs) err_inc = 3'(bresp != 2'b00) + 3'(bid != exp_id);
    if (r_hs) err_inc = 3'(rresp != 2'b00) + 3'(rid != exp_id)
                      + 3'(rlast != last_beat) + 3'(|lane_mis);
  end
  assign err_sum = {1'b0, err_cnt} + 17'(err_inc);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (state == S_DONE) state_nx = S_IDLE;
        if (start) state_nx = (num_txn == 16'd0) ? S_DONE :
                              (mode == 2'd1)     ? S_RD   : S_WR;
      end
      S_WR:      if ((aw_done || aw_hs) && (w_done || w_last_hs)) state_nx = S_WR_RESP;
      S_WR_RESP: if (b_hs) state_nx = more ? S_WR : (cfg.rd_phase ? S_RD : S_DONE);
      S_RD:      if (arready) state_nx = S_RD_DATA;
      S_RD_DATA: if (r_hs && last_beat) state_nx = more ? S_RD : S_DONE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg <= '0; txn <= '0; beat <= '0; gbeat <= '0; cur_addr <= '0;
      aw_done <= 1'b0; w_done <= 1'b0; done_q <= 1'b0; error_q <= 1'b0;
      err_cnt <= '0; first_addr <= '0;
    end else if (start_acc) begin
      cfg.rd_phase <= mode[1];
      cfg.base     <= base_addr;
      cfg.num      <= num_txn;
      cfg.len      <= start_len;
      cfg.seed     <= seed;
      txn <= '0; beat <= '0; gbeat <= '0; cur_addr <= base_addr;
      aw_done <= 1'b0; w_done <= 1'b0; done_q <= 1'b0; error_q <= 1'b0;
      err_cnt <= '0; first_addr <= '0;
    end else begin
      if (state == S_DONE) done_q <= 1'b1;
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs) begin
        beat  <= beat + 8'd1;
        gbeat <= gbeat + 32'd1;
        if (last_beat) w_done <= 1'b1;
      end
      if (b_hs) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        beat    <= '0;
        if (more) begin
          txn      <= txn + 16'd1;
          cur_addr <= cur_addr + stride;
        end else begin
          // Read-back phase restarts the address, ID and pattern sequence.
          txn      <= '0;
          cur_addr <= cfg.base;
          gbeat    <= '0;
        end
      end
      if (r_hs) begin
        beat  <= last_beat ? 8'd0 : beat + 8'd1;
        gbeat <= gbeat + 32'd1;
        if (last_beat && more) begin
          txn      <= txn + 16'd1;
          cur_addr <= cur_addr + stride;
        end
      end
      if (err_inc != 3'd0) begin
        err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        error_q <= 1'b1;
        if (!error_q) first_addr <= cur_addr;
      end
    end
  end
endmodule

// File: tb/tb_axi_traffic_gen.sv
// Directed bench: AXI slave memory with optional stalls/faults, plus a spec-level
// model of addresses, IDs and data pattern checked on every handshake.
module tb_axi_traffic_gen;
  localparam int AW = 32, DW = 128, IW = 4, MB = 16;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic start; logic [1:0] mode; logic [AW-1:0] base_addr; logic [15:0] num_txn;
  logic [7:0] beats; logic [31:0] seed;
  logic busy, done, error; logic [15:0] err_count; logic [AW-1:0] first_err_addr;
  logic [IW-1:0] awid, bid, arid, rid; logic [AW-1:0] awaddr, araddr;
  logic [7:0] awlen, arlen; logic [2:0] awsize, arsize; logic [1:0] awburst, arburst;
  logic awvalid, awready, wvalid, wready, wlast, bvalid, bready, arvalid, arready;
  logic rvalid, rready, rlast; logic [DW-1:0] wdata, rdata; logic [DW/8-1:0] wstrb;
  logic [1:0] bresp, rresp;

  axi_traffic_gen #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_BEATS(MB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .base_addr(base_addr),
    .num_txn(num_txn), .beats(beats), .seed(seed), .busy(busy), .done(done),
    .error(error), .err_count(err_count), .first_err_addr(first_err_addr),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready), .bid(bid), .bresp(bresp), .bvalid(bvalid),
    .bready(bready), .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready), .rid(rid), .rdata(rdata),
    .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready));

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk); #2;
  endtask

  // Model state: run configuration and progress counters.
  logic [1:0] m_mode; logic [31:0] m_base, m_seed; int m_num, m_b;
  bit stall = 0, bresp_bad = 0; int corrupt_beat = -1;
  int aw_t, w_g, ar_t, r_g, wlast_n;
  logic [31:0] aw_log[$]; logic [127:0] w_first; logic [7:0] awlen_first;

  function automatic logic [127:0] pattern(input logic [31:0] s, input int g);
    logic [127:0] p;
    for (int i = 0; i < 4; i++) p[i*32 +: 32] = s + 32'(g) * 32'd4 + 32'(i);
    return p;
  endfunction

  function automatic logic [31:0] txn_addr(input int t);
    return m_base + 32'(t * m_b * 16);
  endfunction

  // Slave memory and monitor; handshakes are decided from the snapshot taken
  // just before each rising edge.
  logic [127:0] mem [logic [31:0]];
  logic s_awv, s_awr, s_wv, s_wr, s_wl, s_bv, s_br, s_arv, s_arr, s_rv, s_rr, s_rl;
  logic [31:0] s_awaddr, s_araddr; logic [7:0] s_awlen, s_arlen; logic [2:0] s_awsize;
  logic [1:0] s_awburst; logic [3:0] s_awid, s_arid; logic [127:0] s_wdata; logic [15:0] s_wstrb;
  bit aw_have, wl_seen, r_act; logic [31:0] sa_addr, sr_addr; logic [3:0] sa_id, sr_id;
  logic [7:0] sr_len; int sr_k; logic [127:0] wq[$];

  initial begin
    awready = 0; wready = 0; bvalid = 0; bid = 0; bresp = 0; arready = 0;
    rvalid = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0;
    {s_awv, s_awr, s_wv, s_wr, s_bv, s_br, s_arv, s_arr, s_rv, s_rr} = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        aw_have = 0; wl_seen = 0; r_act = 0; wq.delete();
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; rlast = 0;
        {s_awv, s_awr, s_wv, s_wr, s_bv, s_br, s_arv, s_arr, s_rv, s_rr} = '0;
      end else begin
        if (s_awv && !s_awr)
          chk("aw_stable", {awvalid, awaddr, awlen, awid}, {1'b1, s_awaddr, s_awlen, s_awid});
        if (s_wv && !s_wr)
          chk("w_stable", {wvalid, wlast, wdata}, {1'b1, s_wl, s_wdata});
        if (s_arv && !s_arr)
          chk("ar_stable", {arvalid, araddr, arlen, arid}, {1'b1, s_araddr, s_arlen, s_arid});
        if (s_awv && s_awr) begin
          chk("awaddr", s_awaddr, txn_addr(aw_t));
          chk("aw_fields", {s_awlen, s_awsize, s_awburst, s_awid},
              {8'(m_b - 1), 3'd4, 2'd1, 4'(aw_t)});
          if (aw_t == 0) awlen_first = s_awlen;
          aw_log.push_back(s_awaddr);
          aw_have = 1; sa_addr = s_awaddr; sa_id = s_awid; aw_t++;
        end
        if (s_wv && s_wr) begin
          chk("wdata", s_wdata, pattern(m_seed, w_g));
          chk("wstrb_wlast", {s_wstrb, s_wl}, {16'hFFFF, (w_g % m_b) == m_b - 1});
          if (w_g == 0) w_first = s_wdata;
          if (s_wl) begin wlast_n++; wl_seen = 1; end
          wq.push_back(s_wdata); w_g++;
        end
        if (s_bv && s_br) bvalid = 0;
        if (s_arv && s_arr) begin
          chk("araddr", s_araddr, txn_addr(ar_t));
          chk("ar_fields", {s_arlen, s_arid}, {8'(m_b - 1), 4'(ar_t)});
          r_act = 1; sr_addr = s_araddr; sr_len = s_arlen; sr_id = s_arid; sr_k = 0; ar_t++;
        end
        if (s_rv && s_rr) begin
          r_g++; sr_k++; rvalid = 0;
          if (s_rl) r_act = 0;
        end
        if (aw_have && wl_seen && !bvalid) begin
          foreach (wq[j]) mem[sa_addr + 32'(j * 16)] = wq[j];
          wq.delete(); aw_have = 0; wl_seen = 0;
          bvalid = 1; bid = sa_id; bresp = bresp_bad ? 2'b10 : 2'b00;
        end
        if (r_act && !rvalid && (!stall || $urandom_range(0, 2) != 0)) begin
          logic [31:0] a;
          a = sr_addr + 32'(sr_k * 16);
          rdata = mem.exists(a) ? mem[a] : '0;
          if (r_g == corrupt_beat) rdata[40] = ~rdata[40];
          rvalid = 1; rlast = (sr_k == int'(sr_len)); rid = sr_id; rresp = 0;
        end
        awready = !stall || ($urandom_range(0, 1) == 1);
        wready  = !stall || ($urandom_range(0, 1) == 1);
        arready = !stall || ($urandom_range(0, 1) == 1);
      end
      #1;
      s_awv = awvalid; s_awr = awready; s_awaddr = awaddr; s_awlen = awlen; s_awid = awid;
      s_awsize = awsize; s_awburst = awburst;
      s_wv = wvalid; s_wr = wready; s_wdata = wdata; s_wl = wlast; s_wstrb = wstrb;
      s_bv = bvalid; s_br = bready;
      s_arv = arvalid; s_arr = arready; s_araddr = araddr; s_arlen = arlen; s_arid = arid;
      s_rv = rvalid; s_rr = rready; s_rl = rlast;
    end
  end

  task automatic launch(input logic [1:0] md, input logic [31:0] base, input int num,
                        input int bts, input logic [31:0] sd);
    m_mode = md; m_base = base; m_num = num; m_seed = sd;
    m_b = (bts == 0 || bts > MB) ? MB : bts;
    aw_t = 0; w_g = 0; ar_t = 0; r_g = 0; wlast_n = 0; aw_log.delete();
    mode = md; base_addr = base; num_txn = 16'(num); beats = 8'(bts); seed = sd; start = 1;
    tick();
    start = 0;
    if (num == 0) chk("zero_done", {done, busy, awvalid, wvalid, arvalid}, 5'b10000);
    else chk("launch", {busy, awvalid, wvalid, arvalid}, (md == 2'd1) ? 4'b1001 : 4'b1110);
  endtask

  task automatic run(input logic [1:0] md, input logic [31:0] base, input int num,
                     input int bts, input logic [31:0] sd);
    int cyc = 0, e = 0, tb;
    bit wr, rd;
    logic [31:0] fa = 0;
    launch(md, base, num, bts, sd);
    while (!done && cyc < 20000) begin tick(); cyc++; end
    chk("done_timeout", done, 1'b1);
    wr = (md != 2'd1); rd = (md != 2'd0); tb = m_num * m_b;
    if (wr && bresp_bad && num > 0) begin e += num; fa = base; end
    if (rd && corrupt_beat >= 0 && corrupt_beat < tb) begin
      if (e == 0) fa = base + 32'((corrupt_beat / m_b) * m_b * 16);
      e += 1;
    end
    chk("end_status", {done, busy, error}, {1'b1, 1'b0, e != 0});
    chk("err_count", err_count, 16'(e));
    chk("first_err_addr", first_err_addr, fa);
    chk("wr_counts", {aw_t, w_g}, {wr ? num : 0, wr ? tb : 0});
    chk("rd_counts", {ar_t, r_g}, {rd ? num : 0, rd ? tb : 0});
  endtask

  initial begin
    start = 0; mode = 0; base_addr = 0; num_txn = 0; beats = 0; seed = 0;
    repeat (3) tick();
    chk("rst_valids", {awvalid, wvalid, arvalid, bready, rready}, 5'b0);
    chk("rst_status", {busy, done, error, err_count, first_err_addr}, '0);
    chk("rst_payload", {awaddr, araddr, awlen, arlen, awid, arid, wlast}, '0);
    chk("rst_wdata", wdata, '0);
    rst_n = 1; tick(); tick();

    run(2'd2, 32'h0, 2, 2, 32'h01234567);
    chk("t1_aw_n", aw_log.size(), 2);
    if (aw_log.size() == 2) begin
      chk("t1_aw0", aw_log[0], 32'h0);
      chk("t1_aw1", aw_log[1], 32'h20);
    end
    chk("t1_awlen", awlen_first, 8'd1);
    chk("t1_beat0", w_first, 128'h0123456A_01234569_01234568_01234567);
    run(2'd1, 32'h0, 2, 2, 32'h01234567);

    stall = 1;
    run(2'd2, 32'h1000, 4, 16, 32'hCAFE0000);
    chk("t2_beats", {w_g, r_g, wlast_n}, {32'd64, 32'd64, 32'd4});
    stall = 0;

    corrupt_beat = 5;
    run(2'd2, 32'h2000, 1, 8, 32'h55550000);
    corrupt_beat = -1;
    chk("t3_err", {error, err_count, first_err_addr}, {1'b1, 16'd1, 32'h2000});

    bresp_bad = 1;
    run(2'd0, 32'h3000, 3, 4, 32'h1);
    bresp_bad = 0;
    chk("t4_err", {err_count, first_err_addr}, {16'd3, 32'h3000});

    run(2'd2, 32'h5000, 0, 4, 32'h0);
    run(2'd0, 32'h4000, 1, 0, 32'h77);
    chk("t6_awlen", {awlen_first, 32'(w_g)}, {8'd15, 32'd16});
    run(2'd3, 32'h6000, 1, 200, 32'h88);
    chk("t7_clamp", awlen_first, 8'd15);
    run(2'd2, 32'hFFFF_FFE0, 2, 2, 32'h9);
    if (aw_log.size() == 2) chk("t8_wrap", aw_log[1], 32'h0);
    else chk("t8_aw_n", aw_log.size(), 2);

    launch(2'd0, 32'h8000, 1, 8, 32'h1111);
    for (int c = 0; c < 100 && w_g < 3; c++) tick();
    chk("rst_at_beat3", {w_g, wvalid}, {32'd3, 1'b1});
    rst_n = 0;
    #1;
    chk("rst_mid_valids", {awvalid, wvalid, arvalid, bready, rready, wlast}, 6'b0);
    chk("rst_mid_status", {busy, done, error}, 3'b0);
    tick(); tick();
    rst_n = 1;
    tick();
    run(2'd2, 32'h7000, 2, 8, 32'hABCD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
